// File: rtl/device2_pkg.sv
// Shared definitions for the device2 dual-FIFO datapath: default widths and
// the arbiter state encoding reported by rr_router2.
package device2_pkg;

   localparam int DATA_W_DEF   = 8;
   localparam int DEST_BIT_DEF = 7;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACTIVE  = 2'd1,
      ST_BLOCKED = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; combinational grant, pointer register
// moves to the non-granted requester after every grant.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic ptr_q;   // 0: requester 0 wins a tie, 1: requester 1 wins a tie

   always_comb begin
      gnt = 2'b00;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         ptr_q <= 1'b0;
      else if (gnt[0])
         ptr_q <= 1'b1;
      else if (gnt[1])
         ptr_q <= 1'b0;
   end

endmodule

// File: rtl/rr_router2.sv
// Pops two FWFT ingress FIFOs round-robin and routes each word to one of two
// egress FIFOs selected by a destination bit, honouring almost_full.
module rr_router2
   import device2_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int DEST_BIT = DEST_BIT_DEF,
   parameter int CNT_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in0_data,
   input  logic              in0_empty,
   input  logic [DATA_W-1:0] in1_data,
   input  logic              in1_empty,
   output logic              read0,
   output logic              read1,
   input  logic              almost_full_o0,
   input  logic              almost_full_o1,
   output logic [DATA_W-1:0] out_data,
   output logic              write_o0,
   output logic              write_o1,
   output logic [CNT_W-1:0]  cnt_o0,
   output logic [CNT_W-1:0]  cnt_o1,
   output logic [1:0]        state
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic              dest0, dest1;
   logic              elig0, elig1;
   logic [1:0]        req, gnt;
   logic              gnt_any;
   logic              sel_dest;
   logic [DATA_W-1:0] sel_data;

   logic [DATA_W-1:0] data_p0;
   logic              wr0_p0, wr1_p0;
   logic [CNT_W-1:0]  cnt0_p0, cnt1_p0;
   arb_state_e        state_q, state_d;

   // A head word is only blocked by the almost_full of the egress it targets.
   assign dest0 = in0_data[DEST_BIT];
   assign dest1 = in1_data[DEST_BIT];
   assign elig0 = !in0_empty && !(dest0 ? almost_full_o1 : almost_full_o0);
   assign elig1 = !in1_empty && !(dest1 ? almost_full_o1 : almost_full_o0);
   assign req   = reset ? 2'b00 : {elig1, elig0};

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .gnt   (gnt)
   );

   assign read0    = gnt[0];
   assign read1    = gnt[1];
   assign gnt_any  = |gnt;
   assign sel_dest = gnt[1] ? dest1 : dest0;
   assign sel_data = gnt[1] ? in1_data : in0_data;

   // Stage p0: registered push into the selected egress, counted as it is set.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_p0 <= '0;
         wr0_p0  <= 1'b0;
         wr1_p0  <= 1'b0;
         cnt0_p0 <= '0;
         cnt1_p0 <= '0;
      end else begin
         wr0_p0 <= gnt_any && !sel_dest;
         wr1_p0 <= gnt_any &&  sel_dest;
         if (gnt_any)
            data_p0 <= sel_data;
         if (gnt_any && !sel_dest)
            cnt0_p0 <= cnt0_p0 + CNT_ONE;
         if (gnt_any && sel_dest)
            cnt1_p0 <= cnt1_p0 + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Status only: derived from this cycle's inputs, never feeds the grant.
   always_comb begin
      state_d = ST_IDLE;
      if (gnt_any)
         state_d = ST_ACTIVE;
      else if (!in0_empty || !in1_empty)
         state_d = ST_BLOCKED;
   end

   assign out_data = data_p0;
   assign write_o0 = wr0_p0;
   assign write_o1 = wr1_p0;
   assign cnt_o0   = cnt0_p0;
   assign cnt_o1   = cnt1_p0;
   assign state    = state_q;

endmodule

// File: tb/tb_rr_router2.sv
// Randomized scoreboard bench for rr_router2 with a queue-based reference
// model of the ingress FIFOs, arbitration and egress pushes.
module tb_rr_router2;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in0_data, in1_data;
   logic       in0_empty, in1_empty;
   logic       read0, read1;
   logic       almost_full_o0, almost_full_o1;
   logic [7:0] out_data;
   logic       write_o0, write_o1;
   logic [7:0] cnt_o0, cnt_o1;
   logic [1:0] state;

   always #5 clk = ~clk;

   rr_router2 #(.DATA_W(8), .DEST_BIT(7), .CNT_W(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .in0_data       (in0_data),
      .in0_empty      (in0_empty),
      .in1_data       (in1_data),
      .in1_empty      (in1_empty),
      .read0          (read0),
      .read1          (read1),
      .almost_full_o0 (almost_full_o0),
      .almost_full_o1 (almost_full_o1),
      .out_data       (out_data),
      .write_o0       (write_o0),
      .write_o1       (write_o1),
      .cnt_o0         (cnt_o0),
      .cnt_o1         (cnt_o1),
      .state          (state)
   );

   typedef struct {
      logic [7:0] data;
      bit         port;
      logic [7:0] c0;
      logic [7:0] c1;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   int         checks = 0;
   int         failures = 0;
   bit         mon_en = 0;
   bit         af0 = 0, af1 = 0;
   int         pref = 0;
   int         m_cnt0 = 0, m_cnt1 = 0;
   logic [7:0] exp_last = 8'h00;
   int         dut_rd0 = 0, dut_rd1 = 0;
   logic       last_rd0, last_rd1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; model decides grant, push and next state.
   task automatic step(input bit rst_v);
      bit         e0, e1, ne;
      int         g;
      int         st;
      logic [7:0] d;
      @(negedge clk);
      reset          = rst_v;
      in0_empty      = (q0.size() == 0);
      in1_empty      = (q1.size() == 0);
      in0_data       = in0_empty ? 8'($urandom) : q0[0];
      in1_data       = in1_empty ? 8'($urandom) : q1[0];
      almost_full_o0 = af0;
      almost_full_o1 = af1;
      #1;
      ne = (q0.size() > 0) || (q1.size() > 0);
      e0 = !rst_v && (q0.size() > 0) && !(q0[0][7] ? af1 : af0);
      e1 = !rst_v && (q1.size() > 0) && !(q1[0][7] ? af1 : af0);
      if (e0 && e1)  g = pref;
      else if (e0)   g = 0;
      else if (e1)   g = 1;
      else           g = -1;
      last_rd0 = read0;
      last_rd1 = read1;
      if (read0 === 1'b1) dut_rd0++;
      if (read1 === 1'b1) dut_rd1++;
      chk("read0", {31'd0, read0}, (g == 0) ? 1 : 0);
      chk("read1", {31'd0, read1}, (g == 1) ? 1 : 0);
      if (g >= 0) begin
         d = (g == 1) ? q1.pop_front() : q0.pop_front();
         if (d[7]) m_cnt1 = (m_cnt1 + 1) % 256;
         else      m_cnt0 = (m_cnt0 + 1) % 256;
         pref = 1 - g;
         exp_last = d;
         sb.push_back('{d, d[7], m_cnt0[7:0], m_cnt1[7:0]});
      end
      if (rst_v) begin
         st = 0; m_cnt0 = 0; m_cnt1 = 0; pref = 0; exp_last = 8'h00;
      end else if (g >= 0) st = 1;
      else if (ne)         st = 2;
      else                 st = 0;
      @(posedge clk);
      #1;
      chk("state", {30'd0, state}, st);
      chk("out_data", {24'd0, out_data}, {24'd0, exp_last});
      if (rst_v) begin
         chk("rst_write", {30'd0, write_o1, write_o0}, 0);
         chk("rst_cnt", {16'd0, cnt_o1, cnt_o0}, 0);
      end
   endtask

   // Every scoreboard entry must appear as a push exactly one cycle later.
   always @(negedge clk) begin
      if (mon_en) begin
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("push_port", {30'd0, write_o1, write_o0}, e.port ? 2 : 1);
            chk("push_data", {24'd0, out_data}, {24'd0, e.data});
            chk("push_cnt0", {24'd0, cnt_o0}, {24'd0, e.c0});
            chk("push_cnt1", {24'd0, cnt_o1}, {24'd0, e.c1});
         end else begin
            chk("idle_write", {30'd0, write_o1, write_o0}, 0);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; in0_empty = 1'b1; in1_empty = 1'b1;
      in0_data = '0; in1_data = '0; almost_full_o0 = 1'b0; almost_full_o1 = 1'b0;

      step(1);
      mon_en = 1;
      step(1);
      step(0);

      // single stream on in0
      q0.push_back(8'h05); q0.push_back(8'h85);
      step(0);
      chk("t2_read0_a", {31'd0, last_rd0}, 1);
      step(0);
      chk("t2_read0_b", {31'd0, last_rd0}, 1);
      step(0);
      chk("t2_cnt0", {24'd0, cnt_o0}, 1);
      chk("t2_cnt1", {24'd0, cnt_o1}, 1);

      // fairness, all to out0
      step(1);
      dut_rd0 = 0; dut_rd1 = 0;
      for (int i = 0; i < 5; i++) begin
         q0.push_back(8'($urandom) & 8'h7f);
         q1.push_back(8'($urandom) & 8'h7f);
      end
      for (int i = 0; i < 10; i++) step(0);
      chk("t3_cnt0", {24'd0, cnt_o0}, 10);
      chk("t3_rd0", dut_rd0, 5);
      chk("t3_rd1", dut_rd1, 5);

      // backpressure isolation
      step(1);
      dut_rd0 = 0;
      af0 = 1;
      q0.push_back(8'h11);
      for (int i = 0; i < 6; i++) q1.push_back(8'h90 + 8'(i));
      for (int i = 0; i < 4; i++) step(0);
      chk("t4_rd0_blocked", dut_rd0, 0);
      chk("t4_cnt1", {24'd0, cnt_o1}, 4);
      af0 = 0;
      step(0);
      step(0);
      chk("t4_rd0_release", dut_rd0, 1);
      for (int i = 0; i < 4; i++) step(0);

      // full block
      step(1);
      af1 = 1;
      q0.push_back(8'h81); q1.push_back(8'h82);
      step(0);
      chk("t5_blocked", {30'd0, state}, 2);
      af1 = 0;
      step(0);
      chk("t5_active", {30'd0, state}, 1);
      step(0); step(0);

      // counter wrap, then reset during a would-be grant
      step(1);
      for (int i = 0; i < 256; i++) q0.push_back(8'($urandom) & 8'h7f);
      for (int i = 0; i < 256; i++) step(0);
      chk("t6_wrap", {24'd0, cnt_o0}, 0);
      q0.push_back(8'h05);
      step(1);
      chk("t6_rst_read", {31'd0, last_rd0}, 0);
      step(0); step(0);

      // random traffic with sporadic backpressure and resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) != 0) q0.push_back(8'($urandom));
         if ($urandom_range(0, 2) != 0) q1.push_back(8'($urandom));
         af0 = ($urandom_range(0, 3) == 0);
         af1 = ($urandom_range(0, 3) == 0);
         step($urandom_range(0, 63) == 0);
      end
      af0 = 0; af1 = 0;
      for (int i = 0; i < 600 && (q0.size() > 0 || q1.size() > 0); i++) step(0);
      chk("drain_q0", q0.size(), 0);
      chk("drain_q1", q1.size(), 0);
      step(0); step(0);
      chk("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
